udma_sdio_cmdq_reg_if: RTL and testbench

Second-generation SDIO register interface for the uDMA peripheral subsystem. It sits between the uDMA config bus and the SDIO controller and adds a parametrised command queue, EOT-captured response and status registers, sticky error flags, and a fully handshaked clock-divider update. The channel RX/TX configuration registers keep their established addresses and semantics.

---
 rtl/udma_sdio_pkg.sv | 49 ++++
 rtl/udma_sdio_cmdq_reg_if_if.sv | 20 ++
 rtl/udma_sdio_cmd_fifo.sv | 74 +++++++
 rtl/udma_sdio_cmdq_reg_if.sv | 268 ++++++++++++++++++++++++++
 tb/tb_udma_sdio_cmdq_reg_if.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udma_sdio_pkg.sv
// Shared definitions for the uDMA SDIO command-queue register interface:
// word addresses of the config registers, STATUS bit positions and the
// queued command entry layout.
package udma_sdio_pkg;

    // Register word addresses (byte address >> 2)
    localparam logic [4:0] REG_RX_SADDR   = 5'h00;
    localparam logic [4:0] REG_RX_SIZE    = 5'h01;
    localparam logic [4:0] REG_RX_CFG     = 5'h02;
    localparam logic [4:0] REG_RX_INTCFG  = 5'h03;
    localparam logic [4:0] REG_TX_SADDR   = 5'h04;
    localparam logic [4:0] REG_TX_SIZE    = 5'h05;
    localparam logic [4:0] REG_TX_CFG     = 5'h06;
    localparam logic [4:0] REG_TX_INTCFG  = 5'h07;
    localparam logic [4:0] REG_CMD_OP     = 5'h08;
    localparam logic [4:0] REG_CMD_ARG    = 5'h09;
    localparam logic [4:0] REG_DATA_SETUP = 5'h0A;
    localparam logic [4:0] REG_STATUS     = 5'h0B;
    localparam logic [4:0] REG_RSP0       = 5'h0C;
    localparam logic [4:0] REG_RSP1       = 5'h0D;
    localparam logic [4:0] REG_RSP2       = 5'h0E;
    localparam logic [4:0] REG_RSP3       = 5'h0F;
    localparam logic [4:0] REG_CLK_DIV    = 5'h10;
    localparam logic [4:0] REG_IRQ_MASK   = 5'h11;

    // STATUS register bit positions
    localparam int ST_FULL    = 4;
    localparam int ST_EMPTY   = 5;
    localparam int ST_BUSY    = 6;
    localparam int ST_ERR_OVF = 8;
    localparam int ST_ERR_CMD = 9;
    localparam int ST_ERR_CLK = 10;
    localparam int ST_FLUSH   = 31;

    // CLK_DIV write strobe bit
    localparam int CLKDIV_LOAD = 8;

    typedef struct packed {
        logic [5:0]  op;
        logic [2:0]  rsp_type;
        logic [31:0] arg;
        logic        data_en;
        logic        data_rwn;
        logic        data_quad;
        logic [9:0]  block_size;
        logic [7:0]  block_num;
    } sdio_cmd_t;

endpackage

// File: rtl/udma_sdio_cmdq_reg_if_if.sv
// uDMA config bus as seen by the SDIO register block. Signal suffixes are
// from the register block's point of view.
interface udma_sdio_cmdq_reg_if_if;
    logic [31:0] cfg_data_i;
    logic [4:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic        cfg_rwn_i;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;

    modport master (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  cfg_data_o, cfg_ready_o
    );

    modport slave (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output cfg_data_o, cfg_ready_o
    );
endinterface

// File: rtl/udma_sdio_cmd_fifo.sv
// Show-ahead command FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; flush empties it and wins over push/pop.
// The head output is forced to zero while the FIFO is empty.
module udma_sdio_cmd_fifo
    import udma_sdio_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  sdio_cmd_t        data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output sdio_cmd_t        data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    sdio_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed since reads are gated by empty
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/udma_sdio_cmdq_reg_if.sv
// SDIO register interface with command queue, EOT-captured response and
// status, sticky errors and handshaked clock-divider update.
// Optional feature macro: UDMA_SDIO_IRQ_MASK_EN adds the IRQ_MASK register
// gating each sticky error into err_irq_o.
module udma_sdio_cmdq_reg_if
    import udma_sdio_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int CMDQ_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    udma_sdio_cmdq_reg_if_if.slave    cfg,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic                      cfg_rx_continuous_o,
    output logic                      cfg_rx_en_o,
    output logic                      cfg_rx_clr_o,
    input  logic                      cfg_rx_en_i,
    input  logic                      cfg_rx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic                      cfg_tx_continuous_o,
    output logic                      cfg_tx_en_o,
    output logic                      cfg_tx_clr_o,
    input  logic                      cfg_tx_en_i,
    input  logic                      cfg_tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    output logic [5:0]                cmd_op_o,
    output logic [2:0]                cmd_rsp_type_o,
    output logic [31:0]               cmd_arg_o,
    output logic                      data_en_o,
    output logic                      data_rwn_o,
    output logic                      data_quad_o,
    output logic [9:0]                data_block_size_o,
    output logic [7:0]                data_block_num_o,
    input  logic                      sdio_eot_i,
    input  logic                      sdio_err_i,
    input  logic [15:0]               sdio_status_i,
    input  logic [127:0]              rsp_data_i,
    output logic [7:0]                clk_div_data_o,
    output logic                      clk_div_valid_o,
    input  logic                      clk_div_ack_i,
    output logic                      err_irq_o
);

    localparam int CNT_W = $clog2(CMDQ_DEPTH + 1);

    logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, rx_saddr_d, tx_saddr_q, tx_saddr_d;
    logic [TRANS_SIZE-1:0]     rx_size_q, rx_size_d, tx_size_q, tx_size_d;
    logic rx_cont_q, rx_cont_d, rx_en_q, rx_en_d, rx_clr_q, rx_clr_d;
    logic tx_cont_q, tx_cont_d, tx_en_q, tx_en_d, tx_clr_q, tx_clr_d;
    logic [5:0]   op_q, op_d;
    logic [2:0]   rsp_type_q, rsp_type_d;
    logic         sen_q, sen_d, srwn_q, srwn_d, squad_q, squad_d;
    logic [7:0]   bnum_q, bnum_d;
    logic [9:0]   bsize_q, bsize_d;
    logic         busy_q, busy_d;
    logic         err_ovf_q, err_ovf_d, err_cmd_q, err_cmd_d, err_clk_q, err_clk_d;
    logic [127:0] rsp_q, rsp_d;
    logic [15:0]  sts_q, sts_d;
    logic [7:0]   div_q, div_d;
    logic         div_vld_q, div_vld_d;
`ifdef UDMA_SDIO_IRQ_MASK_EN
    logic [2:0]   irq_mask_q, irq_mask_d;
`endif

    logic             wr_en, push, pop, flush, drop, div_wr;
    logic [31:0]      wdata, status_rd;
    sdio_cmd_t        push_cmd, head;
    logic [CNT_W-1:0] q_count;
    logic             q_full, q_empty;

    assign wdata  = cfg.cfg_data_i;
    assign wr_en  = cfg.cfg_valid_i & ~cfg.cfg_rwn_i;
    assign push   = wr_en & (cfg.cfg_addr_i == REG_CMD_ARG);
    assign flush  = wr_en & (cfg.cfg_addr_i == REG_STATUS) & wdata[ST_FLUSH];
    assign div_wr = wr_en & (cfg.cfg_addr_i == REG_CLK_DIV) & wdata[CLKDIV_LOAD];
    assign pop    = cmd_valid_o & cmd_ready_i;
    assign drop   = push & q_full & ~pop;

    assign push_cmd = '{op: op_q, rsp_type: rsp_type_q, arg: wdata, data_en: sen_q,
                        data_rwn: srwn_q, data_quad: squad_q, block_size: bsize_q,
                        block_num: bnum_q};

    udma_sdio_cmd_fifo #(.DEPTH(CMDQ_DEPTH)) i_cmd_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign cmd_valid_o       = ~q_empty;
    assign cmd_op_o          = head.op;
    assign cmd_rsp_type_o    = head.rsp_type;
    assign cmd_arg_o         = head.arg;
    assign data_en_o         = head.data_en;
    assign data_rwn_o        = head.data_rwn;
    assign data_quad_o       = head.data_quad;
    assign data_block_size_o = head.block_size;
    assign data_block_num_o  = head.block_num;

    assign cfg_rx_startaddr_o  = rx_saddr_q;
    assign cfg_rx_size_o       = rx_size_q;
    assign cfg_rx_continuous_o = rx_cont_q;
    assign cfg_rx_en_o         = rx_en_q;
    assign cfg_rx_clr_o        = rx_clr_q;
    assign cfg_tx_startaddr_o  = tx_saddr_q;
    assign cfg_tx_size_o       = tx_size_q;
    assign cfg_tx_continuous_o = tx_cont_q;
    assign cfg_tx_en_o         = tx_en_q;
    assign cfg_tx_clr_o        = tx_clr_q;
    assign clk_div_data_o      = div_q;
    assign clk_div_valid_o     = div_vld_q;
    assign cfg.cfg_ready_o     = 1'b1;

`ifdef UDMA_SDIO_IRQ_MASK_EN
    assign err_irq_o = |({err_clk_q, err_cmd_q, err_ovf_q} & irq_mask_q);
`else
    assign err_irq_o = err_clk_q | err_cmd_q | err_ovf_q;
`endif

    // Next-state for register writes, sticky errors, captures and divider handshake
    always_comb begin
        rx_saddr_d = rx_saddr_q;  rx_size_d = rx_size_q;  rx_cont_d = rx_cont_q;
        tx_saddr_d = tx_saddr_q;  tx_size_d = tx_size_q;  tx_cont_d = tx_cont_q;
        rx_en_d = 1'b0;  rx_clr_d = 1'b0;  tx_en_d = 1'b0;  tx_clr_d = 1'b0;
        op_d = op_q;  rsp_type_d = rsp_type_q;
        sen_d = sen_q;  srwn_d = srwn_q;  squad_d = squad_q;
        bnum_d = bnum_q;  bsize_d = bsize_q;
`ifdef UDMA_SDIO_IRQ_MASK_EN
        irq_mask_d = irq_mask_q;
`endif
        if (wr_en) begin
            case (cfg.cfg_addr_i)
                REG_RX_SADDR:   rx_saddr_d = wdata[L2_AWIDTH_NOAL-1:0];
                REG_RX_SIZE:    rx_size_d  = wdata[TRANS_SIZE-1:0];
                REG_RX_CFG: begin
                    rx_cont_d = wdata[0];  rx_en_d = wdata[4];  rx_clr_d = wdata[5];
                end
                REG_TX_SADDR:   tx_saddr_d = wdata[L2_AWIDTH_NOAL-1:0];
                REG_TX_SIZE:    tx_size_d  = wdata[TRANS_SIZE-1:0];
                REG_TX_CFG: begin
                    tx_cont_d = wdata[0];  tx_en_d = wdata[4];  tx_clr_d = wdata[5];
                end
                REG_CMD_OP: begin
                    op_d = wdata[13:8];  rsp_type_d = wdata[2:0];
                end
                REG_DATA_SETUP: begin
                    sen_d = wdata[0];  srwn_d = wdata[1];  squad_d = wdata[2];
                    bnum_d = wdata[15:8];  bsize_d = wdata[25:16];
                end
`ifdef UDMA_SDIO_IRQ_MASK_EN
                REG_IRQ_MASK:   irq_mask_d = wdata[2:0];
`endif
                default: ;
            endcase
        end

        // Write-1-to-clear on STATUS, with a same-cycle set taking priority
        err_ovf_d = (err_ovf_q & ~(wr_en & (cfg.cfg_addr_i == REG_STATUS) & wdata[ST_ERR_OVF])) | drop;
        err_cmd_d = (err_cmd_q & ~(wr_en & (cfg.cfg_addr_i == REG_STATUS) & wdata[ST_ERR_CMD]))
                  | (sdio_eot_i & sdio_err_i);
        err_clk_d = (err_clk_q & ~(wr_en & (cfg.cfg_addr_i == REG_STATUS) & wdata[ST_ERR_CLK]))
                  | (div_wr & div_vld_q);

        // A pop in the same cycle as EOT starts the next command, so BUSY stays set
        busy_d = busy_q;
        if (sdio_eot_i) busy_d = 1'b0;
        if (pop)        busy_d = 1'b1;

        rsp_d = rsp_q;
        sts_d = sts_q;
        if (sdio_eot_i) begin
            rsp_d = rsp_data_i;
            sts_d = sdio_status_i;
        end

        div_vld_d = div_vld_q & ~clk_div_ack_i;
        div_d     = div_q;
        if (div_wr && !div_vld_q) begin
            div_vld_d = 1'b1;
            div_d     = wdata[7:0];
        end
    end

    // Register state; the whole block is cleared by reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_saddr_q <= '0;  rx_size_q <= '0;  rx_cont_q <= 1'b0;
            rx_en_q <= 1'b0;  rx_clr_q <= 1'b0;
            tx_saddr_q <= '0;  tx_size_q <= '0;  tx_cont_q <= 1'b0;
            tx_en_q <= 1'b0;  tx_clr_q <= 1'b0;
            op_q <= '0;  rsp_type_q <= '0;
            sen_q <= 1'b0;  srwn_q <= 1'b0;  squad_q <= 1'b0;
            bnum_q <= '0;  bsize_q <= '0;
            busy_q <= 1'b0;
            err_ovf_q <= 1'b0;  err_cmd_q <= 1'b0;  err_clk_q <= 1'b0;
            rsp_q <= '0;  sts_q <= '0;
            div_q <= '0;  div_vld_q <= 1'b0;
`ifdef UDMA_SDIO_IRQ_MASK_EN
            irq_mask_q <= 3'b111;
`endif
        end else begin
            rx_saddr_q <= rx_saddr_d;  rx_size_q <= rx_size_d;  rx_cont_q <= rx_cont_d;
            rx_en_q <= rx_en_d;  rx_clr_q <= rx_clr_d;
            tx_saddr_q <= tx_saddr_d;  tx_size_q <= tx_size_d;  tx_cont_q <= tx_cont_d;
            tx_en_q <= tx_en_d;  tx_clr_q <= tx_clr_d;
            op_q <= op_d;  rsp_type_q <= rsp_type_d;
            sen_q <= sen_d;  srwn_q <= srwn_d;  squad_q <= squad_d;
            bnum_q <= bnum_d;  bsize_q <= bsize_d;
            busy_q <= busy_d;
            err_ovf_q <= err_ovf_d;  err_cmd_q <= err_cmd_d;  err_clk_q <= err_clk_d;
            rsp_q <= rsp_d;  sts_q <= sts_d;
            div_q <= div_d;  div_vld_q <= div_vld_d;
`ifdef UDMA_SDIO_IRQ_MASK_EN
            irq_mask_q <= irq_mask_d;
`endif
        end
    end

    // Read mux, combinational from the address; unmapped words read zero
    always_comb begin
        status_rd = '0;
        status_rd[3:0]        = 4'(q_count);
        status_rd[ST_FULL]    = q_full;
        status_rd[ST_EMPTY]   = q_empty;
        status_rd[ST_BUSY]    = busy_q;
        status_rd[ST_ERR_OVF] = err_ovf_q;
        status_rd[ST_ERR_CMD] = err_cmd_q;
        status_rd[ST_ERR_CLK] = err_clk_q;
        status_rd[31:16]      = sts_q;
        cfg.cfg_data_o = '0;
        case (cfg.cfg_addr_i)
            REG_RX_SADDR:   cfg.cfg_data_o = 32'(cfg_rx_curr_addr_i);
            REG_RX_SIZE:    cfg.cfg_data_o = 32'(cfg_rx_bytes_left_i);
            REG_RX_CFG:     cfg.cfg_data_o = {26'b0, cfg_rx_pending_i, cfg_rx_en_i, 3'b0, rx_cont_q};
            REG_TX_SADDR:   cfg.cfg_data_o = 32'(cfg_tx_curr_addr_i);
            REG_TX_SIZE:    cfg.cfg_data_o = 32'(cfg_tx_bytes_left_i);
            REG_TX_CFG:     cfg.cfg_data_o = {26'b0, cfg_tx_pending_i, cfg_tx_en_i, 3'b0, tx_cont_q};
            REG_CMD_OP:     cfg.cfg_data_o = {18'b0, op_q, 5'b0, rsp_type_q};
            REG_DATA_SETUP: cfg.cfg_data_o = {6'b0, bsize_q, bnum_q, 5'b0, squad_q, srwn_q, sen_q};
            REG_STATUS:     cfg.cfg_data_o = status_rd;
            REG_RSP0:       cfg.cfg_data_o = rsp_q[31:0];
            REG_RSP1:       cfg.cfg_data_o = rsp_q[63:32];
            REG_RSP2:       cfg.cfg_data_o = rsp_q[95:64];
            REG_RSP3:       cfg.cfg_data_o = rsp_q[127:96];
            REG_CLK_DIV:    cfg.cfg_data_o = {23'b0, div_vld_q, div_q};
`ifdef UDMA_SDIO_IRQ_MASK_EN
            REG_IRQ_MASK:   cfg.cfg_data_o = {29'b0, irq_mask_q};
`endif
            default:        cfg.cfg_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_udma_sdio_cmdq_reg_if.sv
// Randomized self-checking bench for udma_sdio_cmdq_reg_if against a
// queue-based reference model of the register block.
module tb_udma_sdio_cmdq_reg_if;

    localparam int AW = 12;
    localparam int TS = 16;
    localparam int DEPTH = 4;
    localparam logic [4:0] A_RX_SADDR = 5'h00, A_RX_CFG = 5'h02, A_CMD_OP = 5'h08,
                           A_CMD_ARG = 5'h09, A_SETUP = 5'h0A, A_STATUS = 5'h0B,
                           A_RSP0 = 5'h0C, A_CLKDIV = 5'h10, A_MASK = 5'h11, A_NONE = 5'h1F;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    udma_sdio_cmdq_reg_if_if cfg_bus ();

    logic [AW-1:0] rx_saddr, tx_saddr, rx_curr, tx_curr;
    logic [TS-1:0] rx_size, tx_size, rx_left, tx_left;
    logic rx_cont, rx_en, rx_clr, tx_cont, tx_en, tx_clr;
    logic rx_en_i, rx_pend_i, tx_en_i, tx_pend_i;
    logic cmd_valid_o, cmd_ready_i;
    logic [5:0] cmd_op_o;
    logic [2:0] cmd_rsp_type_o;
    logic [31:0] cmd_arg_o;
    logic data_en_o, data_rwn_o, data_quad_o;
    logic [9:0] data_block_size_o;
    logic [7:0] data_block_num_o;
    logic sdio_eot_i, sdio_err_i;
    logic [15:0] sdio_status_i;
    logic [127:0] rsp_data_i;
    logic [7:0] clk_div_data_o;
    logic clk_div_valid_o, clk_div_ack_i, err_irq_o;

    udma_sdio_cmdq_reg_if #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .CMDQ_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg(cfg_bus),
        .cfg_rx_startaddr_o(rx_saddr), .cfg_rx_size_o(rx_size), .cfg_rx_continuous_o(rx_cont),
        .cfg_rx_en_o(rx_en), .cfg_rx_clr_o(rx_clr), .cfg_rx_en_i(rx_en_i),
        .cfg_rx_pending_i(rx_pend_i), .cfg_rx_curr_addr_i(rx_curr), .cfg_rx_bytes_left_i(rx_left),
        .cfg_tx_startaddr_o(tx_saddr), .cfg_tx_size_o(tx_size), .cfg_tx_continuous_o(tx_cont),
        .cfg_tx_en_o(tx_en), .cfg_tx_clr_o(tx_clr), .cfg_tx_en_i(tx_en_i),
        .cfg_tx_pending_i(tx_pend_i), .cfg_tx_curr_addr_i(tx_curr), .cfg_tx_bytes_left_i(tx_left),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_op_o(cmd_op_o),
        .cmd_rsp_type_o(cmd_rsp_type_o), .cmd_arg_o(cmd_arg_o), .data_en_o(data_en_o),
        .data_rwn_o(data_rwn_o), .data_quad_o(data_quad_o), .data_block_size_o(data_block_size_o),
        .data_block_num_o(data_block_num_o), .sdio_eot_i(sdio_eot_i), .sdio_err_i(sdio_err_i),
        .sdio_status_i(sdio_status_i), .rsp_data_i(rsp_data_i), .clk_div_data_o(clk_div_data_o),
        .clk_div_valid_o(clk_div_valid_o), .clk_div_ack_i(clk_div_ack_i), .err_irq_o(err_irq_o)
    );

    // Reference model state
    logic [61:0]  mq[$];
    logic [5:0]   m_op;
    logic [2:0]   m_type;
    logic         m_en, m_rwn, m_quad, m_busy, m_ovf, m_cmd, m_clk, m_div_v;
    logic [7:0]   m_num, m_div;
    logic [9:0]   m_bsize;
    logic [127:0] m_rsp;
    logic [15:0]  m_st;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        {m_op, m_type, m_en, m_rwn, m_quad, m_num, m_bsize} = '0;
        {m_busy, m_ovf, m_cmd, m_clk, m_div_v, m_div, m_rsp, m_st} = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic        wr;
        logic [31:0] d;
        logic [4:0]  a;
        int          sz;
        logic        pop, div_pre;
        wr = cfg_bus.cfg_valid_i && !cfg_bus.cfg_rwn_i;
        d = cfg_bus.cfg_data_i;
        a = cfg_bus.cfg_addr_i;
        sz = mq.size();
        pop = (sz != 0) && cmd_ready_i;
        div_pre = m_div_v;
        if (pop) void'(mq.pop_front());
        if (wr && a == A_CMD_ARG) begin
            if (sz < DEPTH || pop) mq.push_back({m_op, m_type, d, m_en, m_rwn, m_quad, m_bsize, m_num});
        end
        if (wr && a == A_STATUS) begin
            if (d[8]) m_ovf = 1'b0;
            if (d[9]) m_cmd = 1'b0;
            if (d[10]) m_clk = 1'b0;
            if (d[31]) mq.delete();
        end
        if (wr && a == A_CMD_ARG && sz == DEPTH && !pop) m_ovf = 1'b1;
        if (sdio_eot_i) begin
            m_rsp = rsp_data_i;
            m_st = sdio_status_i;
            m_busy = 1'b0;
            if (sdio_err_i) m_cmd = 1'b1;
        end
        if (pop) m_busy = 1'b1;
        if (div_pre && clk_div_ack_i) m_div_v = 1'b0;
        if (wr && a == A_CLKDIV && d[8]) begin
            if (div_pre) m_clk = 1'b1;
            else begin
                m_div = d[7:0];
                m_div_v = 1'b1;
            end
        end
        if (wr && a == A_CMD_OP) begin
            m_op = d[13:8];
            m_type = d[2:0];
        end
        if (wr && a == A_SETUP) {m_bsize, m_num, m_quad, m_rwn, m_en} = {d[25:16], d[15:8], d[2:0]};
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        #1;
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i = 1'b1;
        cmd_ready_i = 1'b0;
        sdio_eot_i = 1'b0;
        sdio_err_i = 1'b0;
        clk_div_ack_i = 1'b0;
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_bus.cfg_valid_i = 1'b1;
        cfg_bus.cfg_rwn_i = 1'b0;
        cfg_bus.cfg_addr_i = a;
        cfg_bus.cfg_data_i = d;
        step();
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i = 1'b1;
        cfg_bus.cfg_addr_i = a;
        #1;
        d = cfg_bus.cfg_data_o;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] st;
        logic [31:0] exp_st;
        int sz;
        sz = mq.size();
        exp_st = {m_st, 5'b0, m_clk, m_cmd, m_ovf, 1'b0, m_busy, sz == 0, sz == DEPTH, 4'(sz)};
        rd(A_STATUS, st);
        check_val({tag, "_status"}, st, exp_st);
        check_val({tag, "_valid"}, cmd_valid_o, sz != 0);
        check_val({tag, "_head"}, {cmd_op_o, cmd_rsp_type_o, cmd_arg_o, data_en_o, data_rwn_o,
                                   data_quad_o, data_block_size_o, data_block_num_o},
                  (sz != 0) ? mq[0] : 62'd0);
        check_val({tag, "_div"}, {clk_div_valid_o, clk_div_data_o}, {m_div_v, m_div});
        check_val({tag, "_irq"}, err_irq_o, m_ovf | m_cmd | m_clk);
    endtask

    task automatic check_rsp(input string tag);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            rd(A_RSP0 + 5'(i), w);
            check_val({tag, "_rsp"}, w, m_rsp[32*i +: 32]);
        end
    endtask

    logic [31:0] rdata;
    logic [31:0] exp_args[4];

    initial begin
        cfg_bus.cfg_valid_i = 1'b0;
        cfg_bus.cfg_rwn_i = 1'b1;
        cfg_bus.cfg_addr_i = '0;
        cfg_bus.cfg_data_i = '0;
        cmd_ready_i = 1'b0;
        sdio_eot_i = 1'b0;
        sdio_err_i = 1'b0;
        sdio_status_i = '0;
        rsp_data_i = '0;
        clk_div_ack_i = 1'b0;
        rx_en_i = 1'b0; rx_pend_i = 1'b0; tx_en_i = 1'b0; tx_pend_i = 1'b0;
        rx_curr = '0; tx_curr = '0; rx_left = '0; tx_left = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        check_all("reset");
        check_rsp("reset");
        check_val("reset_chan", {rx_saddr, rx_size, rx_cont, rx_en, rx_clr,
                                 tx_saddr, tx_size, tx_cont, tx_en, tx_clr}, '0);

        // Single command push, visible the cycle after the ARG write
        bus_wr(A_CMD_OP, 32'h0000_0D03);
        bus_wr(A_SETUP, 32'h0020_0105);
        bus_wr(A_CMD_ARG, 32'h0000_A5A5);
        check_val("cmd1_valid", cmd_valid_o, 1'b1);
        check_val("cmd1_fields", {cmd_op_o, cmd_rsp_type_o, data_block_size_o, data_block_num_o, cmd_arg_o},
                  {6'h0D, 3'd3, 10'h20, 8'h01, 32'h0000_A5A5});
        check_val("cmd1_setup", {data_en_o, data_rwn_o, data_quad_o}, 3'b101);
        check_all("cmd1");

        // Flush, then overflow with five pushes into four entries
        bus_wr(A_STATUS, 32'h8000_0000);
        check_all("flush");
        for (int i = 0; i < 5; i++) bus_wr(A_CMD_ARG, 32'h100 + i);
        check_val("ovf_status", {err_irq_o, cmd_valid_o}, 2'b11);
        check_all("ovf");
        bus_wr(A_STATUS, 32'h0000_0100);
        check_all("ovf_clr");
        check_val("ovf_irq_clr", err_irq_o, 1'b0);

        // Push into a full queue while popping: accepted, no overflow
        cmd_ready_i = 1'b1;
        bus_wr(A_CMD_ARG, 32'h200);
        check_all("full_pushpop");
        exp_args = '{32'h101, 32'h102, 32'h103, 32'h200};
        for (int i = 0; i < 4; i++) begin
            check_val("pop_order", cmd_arg_o, exp_args[i]);
            cmd_ready_i = 1'b1;
            step();
        end
        check_all("drained");

        // End of transfer with error: response/status capture
        rsp_data_i = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        sdio_status_i = 16'h00AB;
        sdio_eot_i = 1'b1;
        sdio_err_i = 1'b1;
        step();
        check_all("eot");
        check_rsp("eot");
        rd(A_RSP0, rdata);
        check_val("rsp0_word", rdata, 32'h7654_3210);
        bus_wr(A_STATUS, 32'h0000_0200);

        // Clock divider handshake
        clk_div_ack_i = 1'b1;
        step();
        check_all("ack_idle");
        bus_wr(A_CLKDIV, 32'h104);
        check_val("div_load", {clk_div_valid_o, clk_div_data_o}, {1'b1, 8'h04});
        bus_wr(A_CLKDIV, 32'h10A);
        check_val("div_busy", {clk_div_valid_o, clk_div_data_o, err_irq_o}, {1'b1, 8'h04, 1'b1});
        check_all("div_rej");
        clk_div_ack_i = 1'b1;
        step();
        check_val("div_ack", clk_div_valid_o, 1'b0);
        bus_wr(A_STATUS, 32'h0000_0400);
        check_all("div_done");

        // Channel config registers
        rx_en_i = 1'b1; rx_pend_i = 1'b1; rx_curr = 12'hABC;
        bus_wr(A_RX_CFG, 32'h31);
        check_val("rx_cfg_pulse", {rx_cont, rx_en, rx_clr}, 3'b111);
        rd(A_RX_CFG, rdata);
        check_val("rx_cfg_rd", rdata, 32'h31);
        rd(A_RX_SADDR, rdata);
        check_val("rx_saddr_rd", rdata, 32'hABC);
        step();
        check_val("rx_cfg_after", {rx_cont, rx_en, rx_clr}, 3'b100);
        rd(A_NONE, rdata);
        check_val("unmapped_rd", rdata, 32'h0);
        rd(A_MASK, rdata);
`ifdef UDMA_SDIO_IRQ_MASK_EN
        check_val("mask_rd", rdata, 32'h7);
`else
        check_val("mask_rd", rdata, 32'h0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: begin
                    cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b0;
                    cfg_bus.cfg_addr_i = A_CMD_ARG; cfg_bus.cfg_data_i = $urandom;
                end
                2, 3: begin
                    cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b0;
                    cfg_bus.cfg_addr_i = (r == 2) ? A_CMD_OP : A_SETUP; cfg_bus.cfg_data_i = $urandom;
                end
                4: begin
                    cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b0; cfg_bus.cfg_addr_i = A_STATUS;
                    cfg_bus.cfg_data_i = {($urandom_range(0, 15) == 0), 20'b0, 3'($urandom), 8'b0};
                end
                5: begin
                    cfg_bus.cfg_valid_i = 1'b1; cfg_bus.cfg_rwn_i = 1'b0;
                    cfg_bus.cfg_addr_i = A_CLKDIV; cfg_bus.cfg_data_i = $urandom_range(0, 511);
                end
                default: ;
            endcase
            cmd_ready_i = ($urandom_range(0, 3) == 0);
            sdio_eot_i = ($urandom_range(0, 7) == 0);
            sdio_err_i = ($urandom_range(0, 3) == 0);
            sdio_status_i = 16'($urandom);
            rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
            clk_div_ack_i = ($urandom_range(0, 3) == 0);
            step();
            check_all("rand");
            if (c % 64 == 0) check_rsp("rand");
        end

        // Asynchronous reset with a populated queue and a pending divider update
        bus_wr(A_STATUS, 32'h8000_0700);
        for (int i = 0; i < 3; i++) bus_wr(A_CMD_ARG, 32'h300 + i);
        bus_wr(A_CLKDIV, 32'h1FF);
        check_all("pre_rst");
        rstn_i = 1'b0;
        model_reset();
        #1;
        check_val("rst_outs", {cmd_valid_o, cmd_op_o, cmd_rsp_type_o, cmd_arg_o, data_en_o, data_rwn_o,
                               data_quad_o, data_block_size_o, data_block_num_o,
                               clk_div_valid_o, clk_div_data_o, err_irq_o}, '0);
        rd(A_STATUS, rdata);
        check_val("rst_status", rdata, 32'h20);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        check_all("post_rst");
        check_rsp("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
